// File: rtl/ps2_pkg.sv
// Shared definitions for the host-side PS/2 receiver: frame FSM states,
// frame geometry, default conditioning constants and the parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam int PS2_DATA_BITS   = 8;
    localparam int PS2_FILTER_DEF  = 4;
    localparam int PS2_TIMEOUT_DEF = 20000;

    // PS/2 uses odd parity over the data byte plus the parity bit
    function automatic logic parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous show-ahead FIFO for received bytes; a push while full only
// lands when a pop frees the head in the same cycle.
module ps2_rx_fifo #(
    parameter int FIFO_BITS = 3,
    parameter int WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WIDTH-1:0]     din,
    input  logic                 pop,
    output logic [WIDTH-1:0]     dout,
    output logic                 full,
    output logic                 empty,
    output logic [FIFO_BITS:0]   count
);

    localparam int DEPTH = 1 << FIFO_BITS;
    localparam int CW    = FIFO_BITS + 1;

    logic [WIDTH-1:0]     mem_r [DEPTH];
    logic [FIFO_BITS-1:0] wr_ptr_r;
    logic [FIFO_BITS-1:0] rd_ptr_r;
    logic [CW-1:0]        cnt_r;
    logic                 do_push_s;
    logic                 do_pop_s;

    assign empty     = (cnt_r == CW'(0));
    assign full      = (cnt_r == CW'(DEPTH));
    assign count     = cnt_r;
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign dout      = empty ? WIDTH'(0) : mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + FIFO_BITS'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + FIFO_BITS'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Storage array, deliberately left out of reset
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/ps2_host_rx.sv
// Host-side PS/2 frame receiver: synchronizes and deglitches the lines,
// decodes 11-bit device frames and queues good bytes in a show-ahead FIFO.
module ps2_host_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_BITS = 3,
    parameter int FILTER    = PS2_FILTER_DEF,
    parameter int TIMEOUT   = PS2_TIMEOUT_DEF
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      ps2_clk,
    input  logic                      ps2_data,
    input  logic                      rd,
    output logic [PS2_DATA_BITS-1:0]  dout,
    output logic                      empty,
    output logic [FIFO_BITS:0]        count,
    output logic                      parity_err,
    output logic                      frame_err,
    output logic                      overflow
);

    localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int BW = $clog2(PS2_DATA_BITS);

    logic                     clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
    logic                     fclk_r, fclk_d_r;
    logic [FW-1:0]            filt_cnt_r;
    logic                     fall_s;

    ps2_state_t               state_r, state_n;
    logic [BW-1:0]            bit_cnt_r, bit_cnt_n;
    logic [PS2_DATA_BITS-1:0] shreg_r, shreg_n;
    logic                     par_r, par_n;
    logic [TW-1:0]            to_cnt_r, to_cnt_n;
    logic                     push_s, perr_s, ferr_s, ovf_s;
    logic                     full_s;

    // Line synchronizers and clock glitch filter; idle lines read as high
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
            fclk_r      <= 1'b1;
            fclk_d_r    <= 1'b1;
            filt_cnt_r  <= '0;
        end else begin
            clk_meta_r  <= ps2_clk;
            clk_sync_r  <= clk_meta_r;
            data_meta_r <= ps2_data;
            data_sync_r <= data_meta_r;
            fclk_d_r    <= fclk_r;
            if (clk_sync_r == fclk_r) begin
                filt_cnt_r <= '0;
            end else if (filt_cnt_r == FW'(FILTER - 1)) begin
                fclk_r     <= clk_sync_r;
                filt_cnt_r <= '0;
            end else begin
                filt_cnt_r <= filt_cnt_r + FW'(1);
            end
        end
    end

    assign fall_s = fclk_d_r & ~fclk_r;

    // Frame state, shift register and inter-edge timeout registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r    <= IDLE;
            bit_cnt_r  <= '0;
            shreg_r    <= '0;
            par_r      <= 1'b0;
            to_cnt_r   <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state_r    <= state_n;
            bit_cnt_r  <= bit_cnt_n;
            shreg_r    <= shreg_n;
            par_r      <= par_n;
            to_cnt_r   <= to_cnt_n;
            parity_err <= perr_s;
            frame_err  <= ferr_s;
            overflow   <= ovf_s;
        end
    end

    // Next-state decode; parity is judged before the stop bit
    always_comb begin
        state_n   = state_r;
        bit_cnt_n = bit_cnt_r;
        shreg_n   = shreg_r;
        par_n     = par_r;
        to_cnt_n  = '0;
        push_s    = 1'b0;
        perr_s    = 1'b0;
        ferr_s    = 1'b0;
        if (fall_s) begin
            case (state_r)
                IDLE: begin
                    if (!data_sync_r) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                        shreg_n   = '0;
                    end else begin
                        state_n   = IDLE;
                    end
                end
                DATA: begin
                    shreg_n   = {data_sync_r, shreg_r[PS2_DATA_BITS-1:1]};
                    bit_cnt_n = bit_cnt_r + BW'(1);
                    if (bit_cnt_r == BW'(PS2_DATA_BITS - 1)) begin
                        state_n = PARITY;
                    end else begin
                        state_n = DATA;
                    end
                end
                PARITY: begin
                    par_n   = data_sync_r;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (!parity_ok(shreg_r, par_r)) begin
                        perr_s = 1'b1;
                    end else if (data_sync_r) begin
                        push_s = 1'b1;
                    end else begin
                        ferr_s = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (state_r == IDLE) begin
            to_cnt_n = '0;
        end else if (to_cnt_r == TW'(TIMEOUT - 1)) begin
            state_n = IDLE;
            ferr_s  = 1'b1;
        end else begin
            to_cnt_n = to_cnt_r + TW'(1);
        end
    end

    assign ovf_s = push_s & full_s & ~rd;

    ps2_rx_fifo #(
        .FIFO_BITS (FIFO_BITS),
        .WIDTH     (PS2_DATA_BITS)
    ) u_fifo (
        .clk   (clk_sys),
        .reset (reset),
        .push  (push_s),
        .din   (shreg_r),
        .pop   (rd),
        .dout  (dout),
        .full  (full_s),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_ps2_host_rx.sv
// Directed bench for ps2_host_rx: bit-bangs PS/2 frames on the pins and
// checks the FIFO outputs and error pulses against hand-computed values.
module tb_ps2_host_rx;

    localparam int TO = 1000;

    logic       clk_sys = 1'b0;
    logic       reset, ps2_clk, ps2_data, rd;
    logic [7:0] dout;
    logic       empty, parity_err, frame_err, overflow;
    logic [3:0] count;

    int n_chk = 0, n_bad = 0;
    int cyc = 0, hp = 100, t_fall = 0;
    int n_pe = 0, n_fe = 0, n_ov = 0, fe_cyc = 0;
    int pe0, fe0, ov0;

    ps2_host_rx #(.FIFO_BITS(3), .FILTER(4), .TIMEOUT(TO)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd         (rd),
        .dout       (dout),
        .empty      (empty),
        .count      (count),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Count every high cycle of each pulse output, sampled mid-cycle
    always @(negedge clk_sys) begin
        if (parity_err) n_pe <= n_pe + 1;
        if (frame_err) begin
            n_fe   <= n_fe + 1;
            fe_cyc <= cyc;
        end
        if (overflow) n_ov <= n_ov + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic snap();
        pe0 = n_pe; fe0 = n_fe; ov0 = n_ov;
    endtask

    // nbits limits how many of the 11 frame bits are sent; glitch_at adds a
    // 2-cycle low blip while the clock is high after that bit
    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop,
                              input int nbits, input logic rd_stop, input int glitch_at);
        logic [10:0] fr;
        fr = {stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            tick(hp / 2);
            ps2_clk = 1'b0;
            t_fall  = cyc;
            if (rd_stop && i == 10) begin
                tick(6);
                rd = 1'b1;
                tick(1);
                rd = 1'b0;
                tick(hp - 7);
            end else begin
                tick(hp);
            end
            ps2_clk = 1'b1;
            if (i == glitch_at) begin
                tick(hp / 4);
                ps2_clk = 1'b0;
                tick(2);
                ps2_clk = 1'b1;
                tick(hp / 2 - hp / 4 - 2);
            end else begin
                tick(hp / 2);
            end
        end
        ps2_data = 1'b1;
        tick(hp / 2);
    endtask

    task automatic pop_one();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd = 1'b0;
        tick(5);
        reset = 1'b0;
        tick(2);
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        check("rst_dout", dout, 8'h00);
        check("rst_pulses", n_pe + n_fe + n_ov, 0);

        // Basic good frame and pop
        snap();
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, -1);
        check("f1c_empty", empty, 0);
        check("f1c_dout", dout, 8'h1C);
        check("f1c_count", count, 1);
        check("f1c_noerr", n_pe + n_fe + n_ov - pe0 - fe0 - ov0, 0);
        pop_one();
        check("pop_empty", empty, 1);
        check("pop_dout", dout, 8'h00);
        check("pop_count", count, 0);

        // Parity error, then bad stop bit
        hp = 60;
        snap();
        send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0, -1);
        check("perr_pulse", n_pe - pe0, 1);
        check("perr_nofe", n_fe - fe0, 0);
        check("perr_count", count, 0);
        snap();
        send_frame(8'hF0, 1'b0, 1'b0, 11, 1'b0, -1);
        check("ferr_pulse", n_fe - fe0, 1);
        check("ferr_nope", n_pe - pe0, 0);
        check("ferr_count", count, 0);

        // Clock stops after 4 data bits
        snap();
        send_frame(8'hA5, 1'b0, 1'b1, 5, 1'b0, -1);
        for (int i = 0; i < TO + 200 && n_fe == fe0; i++) tick(1);
        check("to_pulse", n_fe - fe0, 1);
        check("to_delay", fe_cyc - t_fall, TO + 7);
        check("to_count", count, 0);
        send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b0, -1);
        check("after_to_dout", dout, 8'h5A);
        check("after_to_count", count, 1);
        pop_one();

        // Overflow on the ninth byte
        snap();
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 11, 1'b0, -1);
        check("ovf_count", count, 8);
        check("ovf_pulse", n_ov - ov0, 1);
        for (int i = 1; i <= 8; i++) begin
            check("ovf_rd", dout, i);
            pop_one();
        end
        check("ovf_drained", empty, 1);

        // Full FIFO, read coincides with the push of the ninth byte
        snap();
        for (int i = 8'h11; i <= 8'h18; i++) send_frame(8'(i), 1'b0, 1'b1, 11, 1'b0, -1);
        check("full_count", count, 8);
        send_frame(8'h19, 1'b0, 1'b1, 11, 1'b1, -1);
        check("fullrd_count", count, 8);
        check("fullrd_noovf", n_ov - ov0, 0);
        for (int i = 8'h12; i <= 8'h19; i++) begin
            check("fullrd_rd", dout, i);
            pop_one();
        end
        check("fullrd_drained", count, 0);

        // Short clock glitches are filtered out
        snap();
        ps2_clk = 1'b0;
        tick(2);
        ps2_clk = 1'b1;
        tick(30);
        check("glitch_idle", n_pe + n_fe - pe0 - fe0, 0);
        check("glitch_idle_cnt", count, 0);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 3);
        check("glitch_dout", dout, 8'h1C);
        check("glitch_count", count, 1);
        check("glitch_noerr", n_pe + n_fe - pe0 - fe0, 0);
        pop_one();

        // Reset in the middle of a frame with bytes queued
        send_frame(8'h31, 1'b0, 1'b1, 11, 1'b0, -1);
        send_frame(8'h32, 1'b0, 1'b1, 11, 1'b0, -1);
        send_frame(8'h33, 1'b0, 1'b1, 11, 1'b0, -1);
        check("pre_rst_count", count, 3);
        snap();
        send_frame(8'hFF, 1'b0, 1'b1, 6, 1'b0, -1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_count", count, 0);
        check("mid_rst_dout", dout, 8'h00);
        send_frame(8'h29, 1'b0, 1'b1, 11, 1'b0, -1);
        check("post_rst_dout", dout, 8'h29);
        check("post_rst_count", count, 1);
        check("post_rst_nopulse", n_pe + n_fe + n_ov - pe0 - fe0 - ov0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
